// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU, branch/jump resolution, EX/MEM register
// and an iterative restoring divider that stalls upstream while it runs.
module execute_stage #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  RD,
    input  logic [3:0]  ALUctr,
    input  logic [4:0]  shamt,
    input  logic [31:0] DX_RT,
    input  logic        MemToReg,
    input  logic        MemWrite,
    input  logic [31:0] FD_PC,
    input  logic        jump,
    input  logic [27:0] address,
    input  logic [31:0] offset,
    input  logic        beq,
    input  logic        bne,
    input  logic        bgt,
    output logic [31:0] XM_ALUout,
    output logic [4:0]  XM_RD,
    output logic [31:0] XM_RT,
    output logic        XM_MemToReg,
    output logic        XM_MemWrite,
    output logic        redirect,
    output logic [31:0] target,
    output logic        jnoWB,
    output logic        bnoWB,
    output logic        stall
);

    localparam int CW = $clog2(DIV_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLT = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    function automatic logic [31:0] magnitude(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        return neg ? 32'(-mag) : mag;
    endfunction

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] prod;
    logic [31:0]        alu_res;
    logic               is_ctrl;
    logic               is_div;
    logic               br_taken;

    // divider state
    logic               busy;
    logic [CW-1:0]      step;
    logic [31:0]        dvd;
    logic [31:0]        dvs;
    logic [31:0]        rem;
    logic               q_neg;
    logic               div_zero;
    logic [4:0]         div_rd;

    logic [32:0]        shifted;
    logic [32:0]        diff;
    logic               ge;
    logic [31:0]        rem_nxt;
    logic [31:0]        dvd_nxt;

    assign a_s  = A;
    assign b_s  = B;
    assign prod = a_s * b_s;

    always_comb begin
        alu_res = 32'(A + B);
        case (ALUctr)
            OP_ADD:  alu_res = 32'(A + B);
            OP_SUB:  alu_res = 32'(A - B);
            OP_SLT:  alu_res = {31'd0, a_s < b_s};
            OP_MUL:  alu_res = prod;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_SLL:  alu_res = B << shamt;
            OP_SRL:  alu_res = B >> shamt;
            OP_SRA:  alu_res = b_s >>> shamt;
            default: alu_res = 32'(A + B);
        endcase
    end

    assign is_ctrl  = jump | beq | bne | bgt;
    assign is_div   = (ALUctr == OP_DIV) & ~is_ctrl;
    assign br_taken = (beq & (A == B)) | (bne & (A != B)) | (bgt & (a_s > b_s));

    // One restoring step; a zero divisor always "fits", yielding an all-ones quotient.
    assign shifted = {rem, dvd[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = shifted >= {1'b0, dvs};
    assign rem_nxt = ge ? diff[31:0] : shifted[31:0];
    assign dvd_nxt = {dvd[30:0], ge};

    assign stall = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            XM_ALUout   <= 32'd0;
            XM_RD       <= 5'd0;
            XM_RT       <= 32'd0;
            XM_MemToReg <= 1'b0;
            XM_MemWrite <= 1'b0;
            redirect    <= 1'b0;
            target      <= 32'd0;
            jnoWB       <= 1'b0;
            bnoWB       <= 1'b0;
            busy        <= 1'b0;
            step        <= '0;
            dvd         <= 32'd0;
            dvs         <= 32'd0;
            rem         <= 32'd0;
            q_neg       <= 1'b0;
            div_zero    <= 1'b0;
            div_rd      <= 5'd0;
        end else if (busy) begin
            redirect <= 1'b0;
            jnoWB    <= 1'b0;
            bnoWB    <= 1'b0;
            rem      <= rem_nxt;
            dvd      <= dvd_nxt;
            step     <= step + 1'b1;
            if (step == LAST_STEP) begin
                busy      <= 1'b0;
                XM_ALUout <= apply_sign(dvd_nxt, q_neg & ~div_zero);
                XM_RD     <= div_rd;
            end
        end else begin
            XM_RT       <= DX_RT;
            XM_MemToReg <= MemToReg;
            redirect    <= jump | br_taken;
            jnoWB       <= jump;
            bnoWB       <= ~jump & br_taken;
            if (jump) begin
                target <= {FD_PC[31:28], address};
            end else if (br_taken) begin
                target <= 32'(FD_PC + offset);
            end
            if (is_div) begin
                busy        <= 1'b1;
                step        <= '0;
                dvd         <= magnitude(a_s);
                dvs         <= magnitude(b_s);
                rem         <= 32'd0;
                q_neg       <= A[31] ^ B[31];
                div_zero    <= (B == 32'd0);
                div_rd      <= RD;
                XM_RD       <= 5'd0;
                XM_MemWrite <= 1'b0;
                XM_MemToReg <= 1'b0;
            end else begin
                XM_ALUout   <= alu_res;
                XM_RD       <= is_ctrl ? 5'd0 : RD;
                XM_MemWrite <= is_ctrl ? 1'b0 : MemWrite;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes per-cycle expectations from a
// behavioural model, a monitor pops and compares one entry after every rising edge.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, DX_RT, FD_PC, offset;
    logic [4:0]  RD, shamt;
    logic [3:0]  ALUctr;
    logic        MemToReg, MemWrite, jump, beq, bne, bgt;
    logic [27:0] address;
    logic [31:0] XM_ALUout, XM_RT, target;
    logic [4:0]  XM_RD;
    logic        XM_MemToReg, XM_MemWrite, redirect, jnoWB, bnoWB, stall;

    execute_stage #(.DIV_STEPS(32)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .RD(RD), .ALUctr(ALUctr), .shamt(shamt),
        .DX_RT(DX_RT), .MemToReg(MemToReg), .MemWrite(MemWrite), .FD_PC(FD_PC),
        .jump(jump), .address(address), .offset(offset), .beq(beq), .bne(bne), .bgt(bgt),
        .XM_ALUout(XM_ALUout), .XM_RD(XM_RD), .XM_RT(XM_RT), .XM_MemToReg(XM_MemToReg),
        .XM_MemWrite(XM_MemWrite), .redirect(redirect), .target(target), .jnoWB(jnoWB),
        .bnoWB(bnoWB), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic        m2r, mw, redir, jno, bno, stl;
        logic        chk_alu, chk_rt, chk_tgt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, e.stl});
                chk("XM_RD", {27'd0, XM_RD}, {27'd0, e.rd});
                chk("XM_MemWrite", {31'd0, XM_MemWrite}, {31'd0, e.mw});
                chk("XM_MemToReg", {31'd0, XM_MemToReg}, {31'd0, e.m2r});
                chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
                chk("jnoWB", {31'd0, jnoWB}, {31'd0, e.jno});
                chk("bnoWB", {31'd0, bnoWB}, {31'd0, e.bno});
                if (e.chk_alu) chk("XM_ALUout", XM_ALUout, e.alu);
                if (e.chk_rt)  chk("XM_RT", XM_RT, e.rt);
                if (e.chk_tgt) chk("target", target, e.tgt);
            end
        end
    end

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic [4:0] sh);
        longint p;
        case (op)
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p[31:0];
            end
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ~(a | b);
            4'd9:    return b << sh;
            4'd10:   return b >> sh;
            4'd11:   return $signed(b) >>> sh;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b);
        longint q;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = longint'($signed(a)) / longint'($signed(b));
        return q[31:0];
    endfunction

    task automatic push_zero();
        exp_t e;
        e = '0;
        e.chk_alu = 1'b1;
        e.chk_rt  = 1'b1;
        e.chk_tgt = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic scramble();
        A = $urandom; B = $urandom; RD = 5'($urandom); ALUctr = 4'($urandom);
        shamt = 5'($urandom); DX_RT = $urandom; MemToReg = 1'($urandom);
        MemWrite = 1'($urandom); FD_PC = $urandom; jump = 1'($urandom);
        address = 28'($urandom); offset = $urandom; beq = 1'($urandom);
        bne = 1'($urandom); bgt = 1'($urandom);
    endtask

    task automatic clear_ctrl();
        jump = 0; beq = 0; bne = 0; bgt = 0; MemToReg = 0; MemWrite = 0;
        FD_PC = $urandom; address = 28'($urandom); offset = $urandom; DX_RT = $urandom;
    endtask

    // Model the instruction currently on the inputs and advance the right number of cycles.
    // abort_at >= 0 asserts reset after that many divider edges.
    task automatic issue(input int abort_at);
        exp_t e;
        logic tk;
        int   n;
        logic [31:0] a0, b0;
        logic [4:0]  rd0;
        e = '0;
        if (jump || beq || bne || bgt) begin
            tk = jump || (beq && A == B) || (bne && A != B) || (bgt && $signed(A) > $signed(B));
            e.rt = DX_RT; e.chk_rt = 1'b1; e.m2r = MemToReg;
            e.redir = tk; e.jno = jump; e.bno = tk && !jump;
            if (tk) begin
                e.chk_tgt = 1'b1;
                e.tgt = jump ? {FD_PC[31:28], address} : FD_PC + offset;
            end
            exp_q.push_back(e);
            @(negedge clk);
        end else if (ALUctr == 4'd4) begin
            a0 = A; b0 = B; rd0 = RD;
            e.stl = 1'b1;
            n = (abort_at >= 0) ? abort_at : 32;
            for (int i = 0; i < n; i++) exp_q.push_back(e);
            if (abort_at >= 0) begin
                for (int i = 0; i < n; i++) begin
                    @(negedge clk);
                    scramble();
                end
                rst = 1'b1;
                push_zero();
                @(negedge clk);
                rst = 1'b0;
            end else begin
                e = '0;
                e.alu = div_ref(a0, b0); e.chk_alu = 1'b1; e.rd = rd0;
                exp_q.push_back(e);
                for (int i = 0; i < 32; i++) begin
                    @(negedge clk);
                    scramble();
                end
                @(negedge clk);
            end
        end else begin
            e.alu = alu_ref(A, B, ALUctr, shamt); e.chk_alu = 1'b1;
            e.rd = RD; e.rt = DX_RT; e.chk_rt = 1'b1; e.m2r = MemToReg; e.mw = MemWrite;
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic do_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [4:0] rd, input logic [4:0] sh);
        clear_ctrl();
        A = a; B = b; ALUctr = op; RD = rd; shamt = sh;
        issue(-1);
    endtask

    task automatic do_branch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                             input logic [31:0] off, input logic eq, input logic ne, input logic gt);
        clear_ctrl();
        A = a; B = b; FD_PC = pc; offset = off; beq = eq; bne = ne; bgt = gt;
        ALUctr = 4'($urandom); RD = 5'($urandom); MemWrite = 1'($urandom); shamt = 5'($urandom);
        issue(-1);
    endtask

    task automatic do_jump(input logic [31:0] pc, input logic [27:0] addr);
        clear_ctrl();
        FD_PC = pc; address = addr; jump = 1'b1; beq = 1'($urandom);
        A = $urandom; B = $urandom; ALUctr = 4'd4; RD = 5'($urandom); shamt = 5'($urandom);
        issue(-1);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int abort_at);
        clear_ctrl();
        A = a; B = b; ALUctr = 4'd4; RD = rd; shamt = 5'($urandom);
        issue(abort_at);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          kind;
        rst = 1'b1;
        scramble();
        clear_ctrl();
        repeat (3) begin
            push_zero();
            @(negedge clk);
        end
        rst = 1'b0;

        do_alu(32'd5, 32'd7, 4'd0, 5'd3, 5'd0);
        do_alu(32'd0, 32'h8000_0010, 4'd11, 5'd1, 5'd4);
        do_alu(32'd0, 32'h8000_0010, 4'd10, 5'd2, 5'd4);
        do_alu(32'd0, 32'h8000_0010, 4'd9, 5'd5, 5'd4);
        do_alu(32'hFFFF_FFFF, 32'd1, 4'd2, 5'd6, 5'd0);
        do_branch(32'd9, 32'd9, 32'h100, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
        do_alu(32'd1, 32'd2, 4'd1, 5'd7, 5'd0);
        do_branch(32'd9, 32'd8, 32'h100, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
        do_jump(32'h4000_0010, 28'h000_0200);
        do_alu(32'd3, 32'd4, 4'd3, 5'd8, 5'd0);
        do_div(32'hFFFF_FF9C, 32'd7, 5'd4, -1);
        do_div(32'd1234, 32'd0, 5'd9, -1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 5'd10, -1);
        do_div(32'd1000, 32'd3, 5'd11, 10);
        do_alu(32'd10, 32'd20, 4'd6, 5'd12, 5'd0);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? ra : $urandom;
            if (kind == 0) begin
                do_jump($urandom, 28'($urandom));
            end else if (kind == 1) begin
                do_branch(ra, rb, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            end else if (kind == 2) begin
                case ($urandom_range(0, 3))
                    0:       rb = 32'd0;
                    1:       rb = 32'($urandom_range(1, 20));
                    2:       rb = -32'($urandom_range(1, 20));
                    default: rb = $urandom;
                endcase
                do_div(ra, rb, 5'($urandom), -1);
            end else begin
                op = 4'($urandom);
                if (op == 4'd4) op = 4'd0;
                clear_ctrl();
                A = ra; B = rb; ALUctr = op; RD = 5'($urandom); shamt = 5'($urandom);
                if (op == 4'd0) begin
                    MemToReg = 1'($urandom);
                    MemWrite = ~MemToReg & 1'($urandom);
                end
                issue(-1);
            end
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Consumes decode's registered operands and control, computes the ALU result, and resolves beq/bne/bgt/j.
- Registers the EX/MEM bundle and generates the redirect/squash pulses (jnoWB, bnoWB) fed back upstream.
- Divide is iterative (one quotient bit per cycle); stall holds upstream while a divide is in progress.

Parameters:
DIV_STEPS, 32, divider iterations (one quotient bit per cycle); fixed at data width 32.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
A  input  32  rs operand
B  input  32  rt operand or sign-extended immediate
RD  input  5  destination register, 0 = no writeback
ALUctr  input  4  0 add, 1 sub, 2 slt, 3 mul, 4 div, 5 and, 6 or, 7 xor, 8 nor, 9 sll, 10 srl, 11 sra; 12-15 treated as add
shamt  input  5  shift amount
DX_RT  input  32  rt register value (store data)
MemToReg  input  1  load
MemWrite  input  1  store
FD_PC  input  32  PC+4 of the instruction in EX
jump  input  1  j instruction
address  input  28  jump word address << 2
offset  input  32  sign-extended branch offset << 2
beq  input  1  branch if A==B
bne  input  1  branch if A!=B
bgt  input  1  branch if A>B, signed
XM_ALUout  output  32  result to MEM stage
XM_RD  output  5  destination to MEM stage
XM_RT  output  32  store data to MEM stage
XM_MemToReg  output  1  load flag to MEM stage
XM_MemWrite  output  1  store flag to MEM stage
redirect  output  1  one-cycle pulse: fetch must load target
target  output  32  redirect PC
jnoWB  output  1  one-cycle squash pulse after taken jump
bnoWB  output  1  one-cycle squash pulse after taken branch
stall  output  1  combinational = busy; upstream holds PC/IF/ID registers

Behaviour:
- Reset: all outputs 0, busy=0, divider state cleared. Reset during a divide aborts it; no result is written.
- Accept: each edge with busy=0 accepts the inputs. Single-cycle ops register the XM_* bundle at that edge (latency 1).
- Arithmetic: add/sub wrap mod 2^32. slt is signed, giving 1 or 0. mul gives the low 32 bits of the signed product. nor = ~(A|B).
- Shifts: sll = B<<shamt, srl = B>>shamt, sra = arithmetic B>>shamt. A is ignored for shifts.
- Loads/stores: XM_ALUout = A+B (address), XM_RT = DX_RT, flags are passed through.
- Branches and jump:
  - Branch taken when (beq & A==B) | (bne & A!=B) | (bgt & $signed(A)>$signed(B)).
  - Taken branch: at the accept edge, redirect=1, bnoWB=1, target=FD_PC+offset.
  - Jump: redirect=1, jnoWB=1, target={FD_PC[31:28],address}.
  - Both pulses last exactly one cycle. Priority: jump over branch if both are set.
  - Branch and jump instructions register XM_RD=0 and XM_MemWrite=0.
- Divide (ALUctr=4) with busy=0:
  - Accept edge E0 latches |A|, |B|, signs, RD and sets busy. Bundle outputs become a bubble: XM_RD=0, XM_MemWrite=0, XM_MemToReg=0.
  - Edges E1..E32 each perform one restoring step. While busy, the bubble is held and inputs are ignored.
  - At E32: XM_ALUout = quotient (sign-corrected, truncated toward zero), XM_RD = latched RD, busy cleared.
  - The next instruction, held by decode, is accepted at E33.
  - B==0 gives quotient 0xFFFFFFFF (no sign correction). 0x80000000 / -1 gives 0x80000000.
- Simultaneous redirect and divide cannot occur: a branch/jump with ALUctr=4 is decoded as a branch.
- No forwarding or hazard detection inside this block.

Test Plan:
- Reset then add: A=5, B=7, ALUctr=0, RD=3 -> next edge XM_ALUout=12, XM_RD=3; all outputs 0 while rst=1.
- Shifts and slt: B=0x80000010, shamt=4 -> sra 0xF8000001, srl 0x08000001, sll 0x00000100; slt A=-1, B=1 -> 1.
- beq taken: A=B=9, FD_PC=0x100, offset=0xFFFFFFF8 -> one-cycle redirect=1, bnoWB=1, target=0xF8, XM_RD=0; with A=9, B=8 no pulse.
- Jump: FD_PC=0x40000010, address=0x0000200 -> target=0x40000200, jnoWB one cycle.
- Divide: A=-100, B=7, RD=4 -> stall high 32 cycles, XM_RD=0 throughout, then XM_ALUout=0xFFFFFFF2 (-14), XM_RD=4. Divide by 0 -> 0xFFFFFFFF.
- Reset asserted at cycle 10 of a divide -> stall=0 and XM_RD=0 next cycle; no writeback ever appears.
